// File: rtl/display_sched_pkg.sv
// rtl/display_sched_pkg.sv - shared state type, csel width and default timing for the display refresh scheduler
package display_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    LATCH,
    BLANK,
    DONE
  } state_t;

  localparam int CSEL_W = 3;

  localparam int DEF_CLK_DIV        = 20;
  localparam int DEF_NUM_SEL        = 8;
  localparam int DEF_SHIFT_BITS     = 32;
  localparam int DEF_BLANK_CYCLES   = 8;
  localparam int DEF_REFRESH_PERIOD = 40000;

endpackage

// File: rtl/display_sclk_gen.sv
// rtl/display_sclk_gen.sv - sclk prescaler: low half then high half, with rise/fall tick strobes
module display_sclk_gen #(
  parameter int CLK_DIV = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic sclk,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt_q;
  logic          phase_q;
  logic          half_end;

  assign half_end = (cnt_q == CW'(CLK_DIV - 1));

  // Held at the start of a low half whenever not running, so every group begins identically.
  always_ff @(posedge clk) begin
    if (reset || !run) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else if (half_end) begin
      cnt_q   <= '0;
      phase_q <= ~phase_q;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign sclk      = phase_q;
  assign rise_tick = run && half_end && !phase_q;
  assign fall_tick = run && half_end && phase_q;

endmodule

// File: rtl/display_refresh_scheduler.sv
// rtl/display_refresh_scheduler.sv - front-panel display bus sequencer; optional DISPLAY_SCHED_TEST_PATTERN_EN walking-one source
module display_refresh_scheduler
  import display_sched_pkg::*;
#(
  parameter int CLK_DIV        = DEF_CLK_DIV,
  parameter int NUM_SEL        = DEF_NUM_SEL,
  parameter int SHIFT_BITS     = DEF_SHIFT_BITS,
  parameter int BLANK_CYCLES   = DEF_BLANK_CYCLES,
  parameter int REFRESH_PERIOD = DEF_REFRESH_PERIOD
) (
  input  logic                          clk40m_i,
  input  logic                          reset_i,
`ifdef DISPLAY_SCHED_TEST_PATTERN_EN
  input  logic                          test_pattern_i,
`endif
  input  logic                          enable_i,
  input  logic                          update_i,
  input  logic [NUM_SEL*SHIFT_BITS-1:0] data_ib,
  output logic                          busy_o,
  output logic                          frame_done_o,
  output logic                          latch_o,
  output logic                          blank_o,
  output logic [CSEL_W-1:0]             csel_ob3,
  output logic                          sclk_o,
  output logic                          data_o
);

  localparam int FW = NUM_SEL * SHIFT_BITS;
  localparam int RW = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
  localparam int BW = $clog2(SHIFT_BITS + 1);
  localparam int TW = 16;

  state_t                  state_q, state_d;
  logic                    pending_q;
  logic [RW-1:0]           refresh_q;
  logic [FW-1:0]           fbuf_q;
  logic [FW-1:0]           snap_data;
  logic [SHIFT_BITS-1:0]   shreg_q;
  logic [SHIFT_BITS-1:0]   cur_group;
  logic [TW-1:0]           tcnt_q;
  logic [BW-1:0]           bit_q;
  logic [CSEL_W-1:0]       csel_q;
  logic                    final_q;
  logic                    refresh_wrap;
  logic                    start;
  logic                    last_grp;
  logic                    sclk, rise_tick, fall_tick;

  assign refresh_wrap = (refresh_q == RW'(REFRESH_PERIOD - 1));
  assign start        = (state_q == IDLE) && pending_q && enable_i;
  assign last_grp     = (csel_q == CSEL_W'(NUM_SEL - 1));
  assign cur_group    = fbuf_q[int'(csel_q)*SHIFT_BITS +: SHIFT_BITS];

`ifdef DISPLAY_SCHED_TEST_PATTERN_EN
  logic [7:0] frame_count_q;

  always_ff @(posedge clk40m_i) begin
    if (reset_i) begin
      frame_count_q <= '0;
    end else if (state_q == DONE) begin
      frame_count_q <= frame_count_q + 1'b1;
    end
  end

  always_comb begin
    snap_data = data_ib;
    if (test_pattern_i) begin
      for (int g = 0; g < NUM_SEL; g++) begin
        snap_data[g*SHIFT_BITS +: SHIFT_BITS] =
          SHIFT_BITS'(1) << ((g + int'(frame_count_q)) % SHIFT_BITS);
      end
    end
  end
`else
  assign snap_data = data_ib;
`endif

  display_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .clk       (clk40m_i),
    .reset     (reset_i),
    .run       (state_q == SHIFT),
    .sclk      (sclk),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick)
  );

  always_ff @(posedge clk40m_i) begin
    if (reset_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    busy_o       = 1'b0;
    frame_done_o = 1'b0;
    latch_o      = 1'b0;
    blank_o      = 1'b1;
    data_o       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = LOAD;
      end
      LOAD: begin
        busy_o  = 1'b1;
        blank_o = 1'b0;
        data_o  = cur_group[SHIFT_BITS-1];
        state_d = SHIFT;
      end
      SHIFT: begin
        busy_o  = 1'b1;
        blank_o = 1'b0;
        data_o  = shreg_q[SHIFT_BITS-1];
        // Leave only at the end of the high half that follows the last rising edge.
        if (fall_tick && bit_q == BW'(SHIFT_BITS)) state_d = LATCH;
      end
      LATCH: begin
        busy_o  = 1'b1;
        latch_o = 1'b1;
        if (tcnt_q == TW'(CLK_DIV - 1)) state_d = BLANK;
      end
      BLANK: begin
        busy_o = 1'b1;
        if (tcnt_q == TW'(BLANK_CYCLES - 1)) state_d = (final_q || !enable_i) ? DONE : LOAD;
      end
      DONE: begin
        frame_done_o = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk40m_i) begin
    if (reset_i) begin
      pending_q <= 1'b0;
      refresh_q <= '0;
      fbuf_q    <= '0;
      shreg_q   <= '0;
      tcnt_q    <= '0;
      bit_q     <= '0;
      csel_q    <= '0;
      final_q   <= 1'b0;
    end else begin
      refresh_q <= refresh_wrap ? '0 : refresh_q + 1'b1;
      // A new request in the same cycle as the start keeps pending set for one more frame.
      pending_q <= update_i || refresh_wrap || (pending_q && !start);
      tcnt_q    <= (state_d != state_q) ? '0 : tcnt_q + 1'b1;
      if (start) begin
        fbuf_q <= snap_data;
        csel_q <= '0;
      end
      if (state_q == LOAD) begin
        shreg_q <= cur_group;
        bit_q   <= '0;
      end
      if (state_q == SHIFT) begin
        if (rise_tick) bit_q <= bit_q + 1'b1;
        if (fall_tick) shreg_q <= shreg_q << 1;
      end
      if (state_q == LATCH && state_d == BLANK) begin
        final_q <= last_grp || !enable_i;
        if (!last_grp && enable_i) csel_q <= csel_q + 1'b1;
      end
      if (state_d == DONE) csel_q <= '0;
    end
  end

  assign csel_ob3 = csel_q;
  assign sclk_o   = sclk;

endmodule

// File: tb/tb_display_refresh_scheduler.sv
// tb/tb_display_refresh_scheduler.sv - self-checking bench for display_refresh_scheduler
module tb_display_refresh_scheduler;

  localparam int CD = 2;
  localparam int NS = 2;
  localparam int SB = 8;
  localparam int BC = 3;
  localparam int RP = 1000;
  localparam int G         = 1 + 2*CD*SB + CD + BC;
  localparam int SH_END    = 2*CD*SB;
  localparam int LATCH_END = SH_END + CD;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset_i  = 1'b1;
  logic             enable_i = 1'b0;
  logic             update_i = 1'b0;
  logic [NS*SB-1:0] data_ib  = '0;
`ifdef DISPLAY_SCHED_TEST_PATTERN_EN
  logic             test_pattern_i = 1'b0;
`endif
  logic       busy_o, frame_done_o, latch_o, blank_o, sclk_o, data_o;
  logic [2:0] csel_ob3;

  display_refresh_scheduler #(
    .CLK_DIV(CD), .NUM_SEL(NS), .SHIFT_BITS(SB), .BLANK_CYCLES(BC), .REFRESH_PERIOD(RP)
  ) dut (
    .clk40m_i     (clk),
    .reset_i      (reset_i),
`ifdef DISPLAY_SCHED_TEST_PATTERN_EN
    .test_pattern_i(test_pattern_i),
`endif
    .enable_i     (enable_i),
    .update_i     (update_i),
    .data_ib      (data_ib),
    .busy_o       (busy_o),
    .frame_done_o (frame_done_o),
    .latch_o      (latch_o),
    .blank_o      (blank_o),
    .csel_ob3     (csel_ob3),
    .sclk_o       (sclk_o),
    .data_o       (data_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: frame position as a plain cycle offset from the snapshot.
  int               m_k, m_ref, m_fc;
  bit               m_done, m_stop, m_pend;
  logic [NS*SB-1:0] m_frame;

  int         cyc, done_cnt, done_cycle, max_csel, cur_latch_w, cap_n;
  bit         prev_sclk;
  logic [7:0] cap_byte;
  logic [7:0] cap_q[$];
  int         latch_w_q[$];
  int         latch_csel_q[$];

  typedef struct {
    bit          rst;
    bit          en;
    bit          upd;
    logic [15:0] data;
    int          ncyc;
    int          exp_done;
    bit          exp_busy;
    bit          exp_blank;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [NS*SB-1:0] snapshot();
    logic [NS*SB-1:0] v;
    logic [SB-1:0]    one;
    v = data_ib;
`ifdef DISPLAY_SCHED_TEST_PATTERN_EN
    if (test_pattern_i) begin
      for (int g = 0; g < NS; g++) begin
        one = '0;
        one[(g + m_fc) % SB] = 1'b1;
        v[g*SB +: SB] = one;
      end
    end
`endif
    one = '0;
    return v | {NS{one}};
  endfunction

  task automatic model_edge();
    bit st, set;
    int pos, grp;
    set = update_i || (m_ref == RP-1);
    if (reset_i) begin
      m_k = 0; m_done = 0; m_stop = 0; m_pend = 0; m_ref = 0; m_fc = 0;
      return;
    end
    m_ref = (m_ref == RP-1) ? 0 : m_ref + 1;
    st = 0;
    if (m_done) begin
      m_done = 0; m_k = 0; m_fc = (m_fc + 1) % 256;
    end else if (m_k == 0) begin
      if (m_pend && enable_i) begin
        st = 1; m_k = 1; m_stop = 0; m_frame = snapshot();
      end
    end else begin
      pos = (m_k - 1) % G;
      grp = (m_k - 1) / G;
      if (pos == LATCH_END && !enable_i) m_stop = 1;
      if (pos == G-1 && (m_stop || !enable_i || grp == NS-1)) m_done = 1;
      else m_k++;
    end
    m_pend = set || (m_pend && !st);
  endtask

  // {busy, frame_done, latch, blank, csel[2:0], sclk, data}
  function automatic logic [8:0] model_out();
    int pos, grp, q, cs;
    logic [SB-1:0] g;
    if (m_done) return 9'b0_1_0_1_000_0_0;
    if (m_k == 0) return 9'b0_0_0_1_000_0_0;
    pos = (m_k - 1) % G;
    grp = (m_k - 1) / G;
    g = m_frame[grp*SB +: SB];
    if (pos == 0) return {1'b1, 1'b0, 1'b0, 1'b0, 3'(grp), 1'b0, g[SB-1]};
    if (pos <= SH_END) begin
      q = pos - 1;
      return {1'b1, 1'b0, 1'b0, 1'b0, 3'(grp), 1'((q % (2*CD)) >= CD), g[SB-1-q/(2*CD)]};
    end
    if (pos <= LATCH_END) return {1'b1, 1'b0, 1'b1, 1'b1, 3'(grp), 1'b0, 1'b0};
    cs = (grp < NS-1 && !m_stop) ? grp + 1 : grp;
    return {1'b1, 1'b0, 1'b0, 1'b1, 3'(cs), 1'b0, 1'b0};
  endfunction

  task automatic clear_mon();
    cyc = 0; done_cnt = 0; done_cycle = 0; max_csel = 0; cur_latch_w = 0; cap_n = 0;
    cap_byte = '0; prev_sclk = sclk_o;
    cap_q.delete(); latch_w_q.delete(); latch_csel_q.delete();
  endtask

  task automatic monitor();
    cyc++;
    if (frame_done_o) begin
      done_cnt++;
      if (done_cycle == 0) done_cycle = cyc;
    end
    if (latch_o) begin
      if (cur_latch_w == 0) latch_csel_q.push_back(int'(csel_ob3));
      cur_latch_w++;
    end else if (cur_latch_w > 0) begin
      latch_w_q.push_back(cur_latch_w);
      cur_latch_w = 0;
    end
    if (int'(csel_ob3) > max_csel) max_csel = int'(csel_ob3);
    if (sclk_o && !prev_sclk) begin
      cap_byte = {cap_byte[6:0], data_o};
      cap_n++;
      if (cap_n % 8 == 0) cap_q.push_back(cap_byte);
    end
    prev_sclk = sclk_o;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    monitor();
    check("outputs", {busy_o, frame_done_o, latch_o, blank_o, csel_ob3, sclk_o, data_o}, model_out());
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    steps(3);
    reset_i = 1'b0;
  endtask

  task automatic pulse_update();
    update_i = 1'b1;
    step();
    update_i = 1'b0;
  endtask

  task automatic run_until_done(input int target, input int maxc, input string name);
    for (int i = 0; i < maxc && done_cnt < target; i++) step();
    check(name, 64'(done_cnt >= target), 64'd1);
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{1, 0, 0, 16'h0000,  3, 0, 0, 1};
    vecs[1] = '{0, 1, 1, 16'h3CA5, 90, 1, 0, 1};
    vecs[2] = '{0, 1, 0, 16'h1234, 50, 0, 0, 1};
    vecs[3] = '{0, 0, 1, 16'h5678, 40, 0, 0, 1};
    vecs[4] = '{0, 1, 0, 16'h9ABC, 40, 0, 1, 0};
    vecs[5] = '{0, 1, 0, 16'hDEF0, 60, 1, 0, 1};

    m_k = 0; m_done = 0; m_stop = 0; m_pend = 0; m_ref = 0; m_fc = 0; m_frame = '0;
    clear_mon();

    for (int v = 0; v < 6; v++) begin
      reset_i  = vecs[v].rst;
      enable_i = vecs[v].en;
      update_i = vecs[v].upd;
      data_ib  = vecs[v].data;
      clear_mon();
      for (int i = 0; i < vecs[v].ncyc; i++) begin
        step();
        update_i = 1'b0;
      end
      check($sformatf("vec%0d_done", v), 64'(done_cnt), 64'(vecs[v].exp_done));
      check($sformatf("vec%0d_busy", v), 64'(busy_o), 64'(vecs[v].exp_busy));
      check($sformatf("vec%0d_blank", v), 64'(blank_o), 64'(vecs[v].exp_blank));
    end
    reset_i = 1'b0;

    // Serial content, latch width, csel order and frame latency.
    do_reset();
    clear_mon();
    enable_i = 1'b1;
    data_ib  = 16'h3CA5;
    pulse_update();
    run_until_done(1, 200, "t2_timeout");
    steps(5);
    check("t2_bytes", 64'(cap_q.size()), 64'd2);
    if (cap_q.size() == 2) begin
      check("t2_group0", 64'(cap_q[0]), 64'hA5);
      check("t2_group1", 64'(cap_q[1]), 64'h3C);
    end
    check("t2_latches", 64'(latch_w_q.size()), 64'd2);
    if (latch_w_q.size() == 2) begin
      check("t2_latch_w0", 64'(latch_w_q[0]), 64'd2);
      check("t2_latch_w1", 64'(latch_w_q[1]), 64'd2);
      check("t2_csel0", 64'(latch_csel_q[0]), 64'd0);
      check("t2_csel1", 64'(latch_csel_q[1]), 64'd1);
    end
    check("t2_done_cnt", 64'(done_cnt), 64'd1);
    check("t2_done_cycle", 64'(done_cycle), 64'd78);

    // Coalescing: two requests mid-frame give one extra frame, then nothing until the refresh wrap.
    do_reset();
    clear_mon();
    pulse_update();
    steps(20);
    pulse_update();
    steps(10);
    pulse_update();
    run_until_done(2, 400, "t3_timeout");
    steps(100);
    check("t3_done_cnt", 64'(done_cnt), 64'd2);
    check("t3_idle_busy", 64'(busy_o), 64'd0);
    run_until_done(3, 1000, "t3_refresh_frame");
    check("t3_refresh_late", 64'(done_cycle < cyc - 900), 64'd1);

    // Enable dropped during group0 shift.
    do_reset();
    clear_mon();
    data_ib = 16'h3CA5;
    pulse_update();
    steps(10);
    enable_i = 1'b0;
    run_until_done(1, 200, "t4_timeout");
    steps(5);
    check("t4_bytes", 64'(cap_q.size()), 64'd1);
    if (cap_q.size() == 1) check("t4_group0", 64'(cap_q[0]), 64'hA5);
    check("t4_max_csel", 64'(max_csel), 64'd0);
    check("t4_latches", 64'(latch_w_q.size()), 64'd1);
    check("t4_blank_idle", 64'(blank_o), 64'd1);
    enable_i = 1'b1;

    // Data change mid-frame only reaches the next frame.
    do_reset();
    clear_mon();
    data_ib = 16'h7E81;
    pulse_update();
    steps(10);
    data_ib = 16'hC312;
    pulse_update();
    run_until_done(2, 400, "t5_timeout");
    check("t5_bytes", 64'(cap_q.size()), 64'd4);
    if (cap_q.size() == 4) begin
      check("t5_f0g0", 64'(cap_q[0]), 64'h81);
      check("t5_f0g1", 64'(cap_q[1]), 64'h7E);
      check("t5_f1g0", 64'(cap_q[2]), 64'h12);
      check("t5_f1g1", 64'(cap_q[3]), 64'hC3);
    end

    // Reset mid-shift with a request pending.
    do_reset();
    clear_mon();
    pulse_update();
    steps(20);
    pulse_update();
    steps(5);
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    check("t6_reset_outs", {busy_o, frame_done_o, latch_o, blank_o, csel_ob3, sclk_o, data_o},
          9'b0_0_0_1_000_0_0);
    clear_mon();
    steps(150);
    check("t6_no_frame", 64'(done_cnt), 64'd0);
    check("t6_busy", 64'(busy_o), 64'd0);
`ifdef DISPLAY_SCHED_TEST_PATTERN_EN
    test_pattern_i = 1'b1;
    do_reset();
    clear_mon();
    pulse_update();
    run_until_done(1, 200, "t6p_timeout0");
    pulse_update();
    run_until_done(2, 200, "t6p_timeout1");
    check("t6p_bytes", 64'(cap_q.size()), 64'd4);
    if (cap_q.size() == 4) begin
      check("t6p_f0g0", 64'(cap_q[0]), 64'h01);
      check("t6p_f0g1", 64'(cap_q[1]), 64'h02);
      check("t6p_f1g0", 64'(cap_q[2]), 64'h02);
    end
    test_pattern_i = 1'b0;
`endif

    // Randomized traffic checked every cycle against the model.
    do_reset();
    clear_mon();
    for (int i = 0; i < 4000; i++) begin
      enable_i = ($urandom_range(0, 9) != 0);
      update_i = ($urandom_range(0, 59) == 0);
      reset_i  = ($urandom_range(0, 1999) == 0);
      if ($urandom_range(0, 6) == 0) data_ib = 16'($urandom);
      step();
    end
    reset_i  = 1'b0;
    update_i = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
